// File: rtl/keyboard_tx_queue.sv
// Buffers key events from the PS/2 decoder and feeds them to the UART transmitter,
// expanding cursor/navigation keys into three-byte VT100 escape sequences.
module keyboard_tx_queue #(
    parameter int DEPTH         = 16,
    parameter bit ENABLE_ESCAPE = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     keyValid,
    input  logic [7:0]               keyCode,
    input  logic                     keySpecial,
    output logic                     txStart,
    output logic [7:0]               txData,
    input  logic                     txBusy,
    output logic [$clog2(DEPTH):0]   fifoCount,
    output logic                     overflow,
    output logic                     idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SEND, HOLD, WAIT} state_t;

    state_t         state, stateNext;
    logic [8:0]     mem [DEPTH];
    logic [AW-1:0]  rdPtr, wrPtr;
    logic [CW-1:0]  countNext;
    logic           fifoFull, fifoEmpty;
    logic           push, pop;

    logic [8:0]     head;
    logic           headDrop;
    logic [7:0]     holdCode, holdCodeNext;
    logic           holdSpecial, holdSpecialNext;
    logic [1:0]     idx, idxNext;
    logic [1:0]     len, lenNext;
    logic [7:0]     curByte;
    logic           txStartNext;
    logic [7:0]     txDataNext;

    assign fifoFull  = (fifoCount == CW'(DEPTH));
    assign fifoEmpty = (fifoCount == '0);
    // A full FIFO still accepts a push when the FSM pops on the same edge.
    assign push      = keyValid && (!fifoFull || pop);
    assign head      = mem[rdPtr];
    assign headDrop  = head[8] && (!ENABLE_ESCAPE || (head[2:0] >= 3'd6));

    always_comb begin
        countNext = fifoCount;
        if (push && !pop) begin
            countNext = fifoCount + CW'(1);
        end else if (!push && pop) begin
            countNext = fifoCount - CW'(1);
        end
    end

    always_comb begin
        curByte = 8'h00;
        case (idx)
            2'd0:    curByte = holdSpecial ? 8'h1B : holdCode;
            2'd1:    curByte = 8'h5B;
            default: begin
                case (holdCode[2:0])
                    3'd0:    curByte = 8'h41;
                    3'd1:    curByte = 8'h42;
                    3'd2:    curByte = 8'h43;
                    3'd3:    curByte = 8'h44;
                    3'd4:    curByte = 8'h48;
                    3'd5:    curByte = 8'h46;
                    default: curByte = 8'h00;
                endcase
            end
        endcase
    end

    always_comb begin
        stateNext       = state;
        pop             = 1'b0;
        holdCodeNext    = holdCode;
        holdSpecialNext = holdSpecial;
        idxNext         = idx;
        lenNext         = len;
        txStartNext     = 1'b0;
        txDataNext      = txData;
        case (state)
            IDLE: begin
                if (!fifoEmpty && !txBusy) begin
                    pop             = 1'b1;
                    holdCodeNext    = head[7:0];
                    holdSpecialNext = head[8];
                    idxNext         = 2'd0;
                    lenNext         = head[8] ? 2'd3 : 2'd1;
                    // Unusable special entries are swallowed without leaving IDLE.
                    if (!headDrop) begin
                        stateNext = SEND;
                    end
                end
            end
            SEND: begin
                txStartNext = 1'b1;
                txDataNext  = curByte;
                stateNext   = HOLD;
            end
            HOLD: begin
                stateNext = WAIT;
            end
            WAIT: begin
                if (!txBusy) begin
                    if (idx == len - 2'd1) begin
                        stateNext = IDLE;
                    end else begin
                        idxNext   = idx + 2'd1;
                        stateNext = SEND;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= {keySpecial, keyCode};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rdPtr       <= '0;
            wrPtr       <= '0;
            fifoCount   <= '0;
            overflow    <= 1'b0;
            idle        <= 1'b1;
            holdCode    <= 8'h00;
            holdSpecial <= 1'b0;
            idx         <= 2'd0;
            len         <= 2'd1;
            txStart     <= 1'b0;
            txData      <= 8'h00;
        end else begin
            state       <= stateNext;
            fifoCount   <= countNext;
            holdCode    <= holdCodeNext;
            holdSpecial <= holdSpecialNext;
            idx         <= idxNext;
            len         <= lenNext;
            txStart     <= txStartNext;
            txData      <= txDataNext;
            idle        <= (countNext == '0) && (stateNext == IDLE);
            if (push) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            if (keyValid && fifoFull && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keyboard_tx_queue.sv
// Directed self-checking bench for keyboard_tx_queue with a simple
// async_transmitter busy model and a byte-capture monitor.
module tb_keyboard_tx_queue;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       keyValid, keyValid2;
    logic [7:0] keyCode;
    logic       keySpecial;
    logic       txStart, txStart2;
    logic [7:0] txData, txData2;
    logic       txBusy;
    logic [$clog2(DEPTH):0] fifoCount, fifoCount2;
    logic       overflow, overflow2;
    logic       idle, idle2;

    logic       busyForce;
    int         busyCnt = 0;
    int         startWhileBusy = 0;
    logic [7:0] capQ[$];
    logic [7:0] cap2[$];

    int vectorCount = 0;
    int missCount   = 0;
    int base;

    keyboard_tx_queue #(.DEPTH(DEPTH), .ENABLE_ESCAPE(1'b1)) dut (
        .clk(clk), .rst(rst), .keyValid(keyValid), .keyCode(keyCode),
        .keySpecial(keySpecial), .txStart(txStart), .txData(txData),
        .txBusy(txBusy), .fifoCount(fifoCount), .overflow(overflow), .idle(idle)
    );

    keyboard_tx_queue #(.DEPTH(4), .ENABLE_ESCAPE(1'b0)) dut2 (
        .clk(clk), .rst(rst), .keyValid(keyValid2), .keyCode(keyCode),
        .keySpecial(keySpecial), .txStart(txStart2), .txData(txData2),
        .txBusy(1'b0), .fifoCount(fifoCount2), .overflow(overflow2), .idle(idle2)
    );

    always #5 clk = ~clk;

    assign txBusy = busyForce || (busyCnt != 0);

    // Transmitter model: a start pulse keeps it busy for four cycles.
    always @(posedge clk) begin
        if (txStart) begin
            capQ.push_back(txData);
            if (txBusy) startWhileBusy <= startWhileBusy + 1;
            busyCnt <= 4;
        end else if (busyCnt != 0) begin
            busyCnt <= busyCnt - 1;
        end
        if (txStart2) cap2.push_back(txData2);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] code, input logic special);
        keyCode    = code;
        keySpecial = special;
        keyValid   = 1'b1;
        @(negedge clk);
        keyValid   = 1'b0;
        keySpecial = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; keyValid = 1'b0; keyValid2 = 1'b0;
        keyCode = 8'h00; keySpecial = 1'b0; busyForce = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstTxStart", 32'(txStart), 0);
        checkOutput("rstTxData", 32'(txData), 0);
        checkOutput("rstCount", 32'(fifoCount), 0);
        checkOutput("rstOverflow", 32'(overflow), 0);
        checkOutput("rstIdle", 32'(idle), 1);
        rst = 1'b1;
        @(negedge clk);

        // Single plain key and its latency
        base = capQ.size();
        applyStimulus(8'h61, 1'b0);
        checkOutput("plainCountPushed", 32'(fifoCount), 1);
        checkOutput("plainNotIdle", 32'(idle), 0);
        @(negedge clk);
        checkOutput("plainNoEarlyStart", 32'(txStart), 0);
        checkOutput("plainPopped", 32'(fifoCount), 0);
        @(negedge clk);
        checkOutput("plainStart", 32'(txStart), 1);
        checkOutput("plainData", 32'(txData), 32'h61);
        repeat (20) @(negedge clk);
        checkOutput("plainByteCount", 32'(capQ.size() - base), 1);
        if (capQ.size() > base) checkOutput("plainByte", 32'(capQ[base]), 32'h61);
        checkOutput("plainIdleAfter", 32'(idle), 1);
        checkOutput("plainDataHeld", 32'(txData), 32'h61);

        // Special key: cursor up
        base = capQ.size();
        applyStimulus(8'h00, 1'b1);
        repeat (60) @(negedge clk);
        checkOutput("escByteCount", 32'(capQ.size() - base), 3);
        if (capQ.size() >= base + 3) begin
            checkOutput("escByte0", 32'(capQ[base]), 32'h1B);
            checkOutput("escByte1", 32'(capQ[base+1]), 32'h5B);
            checkOutput("escByte2", 32'(capQ[base+2]), 32'h41);
        end
        checkOutput("escStartWhileBusy", 32'(startWhileBusy), 0);

        // Full FIFO: simultaneous push and pop
        doReset();
        busyForce = 1'b1;
        for (int i = 0; i < DEPTH; i++) applyStimulus(8'h40 + 8'(i), 1'b0);
        checkOutput("fullCount", 32'(fifoCount), DEPTH);
        checkOutput("fullNoOverflow", 32'(overflow), 0);
        base = capQ.size();
        busyForce = 1'b0;
        applyStimulus(8'h7E, 1'b0);
        checkOutput("pushPopCount", 32'(fifoCount), DEPTH);
        checkOutput("pushPopNoOverflow", 32'(overflow), 0);
        repeat (250) @(negedge clk);
        checkOutput("pushPopByteCount", 32'(capQ.size() - base), DEPTH + 1);
        for (int i = 0; i <= DEPTH && base + i < capQ.size(); i++)
            checkOutput("pushPopOrder", 32'(capQ[base+i]), (i < DEPTH) ? 32'h40 + i : 32'h7E);
        checkOutput("pushPopIdle", 32'(idle), 1);

        // Overflow: DEPTH+2 pushes while the transmitter is busy
        busyForce = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) applyStimulus(8'h20 + 8'(i), 1'b0);
        checkOutput("ovfCount", 32'(fifoCount), DEPTH);
        checkOutput("ovfFlag", 32'(overflow), 1);
        base = capQ.size();
        busyForce = 1'b0;
        repeat (200) @(negedge clk);
        checkOutput("ovfByteCount", 32'(capQ.size() - base), DEPTH);
        for (int i = 0; i < DEPTH && base + i < capQ.size(); i++)
            checkOutput("ovfOrder", 32'(capQ[base+i]), 32'h20 + i);
        checkOutput("ovfIdle", 32'(idle), 1);
        checkOutput("ovfSticky", 32'(overflow), 1);

        // Pointer wrap: stream 3*DEPTH keys slower than the drain rate
        doReset();
        base = capQ.size();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            applyStimulus(8'h80 + 8'(i), 1'b0);
            repeat (8) @(negedge clk);
        end
        repeat (30) @(negedge clk);
        checkOutput("wrapByteCount", 32'(capQ.size() - base), 3 * DEPTH);
        for (int i = 0; i < 3 * DEPTH && base + i < capQ.size(); i++)
            checkOutput("wrapOrder", 32'(capQ[base+i]), 32'h80 + i);
        checkOutput("wrapNoOverflow", 32'(overflow), 0);

        // Invalid special indices are consumed silently
        busyForce = 1'b1;
        applyStimulus(8'h06, 1'b1);
        applyStimulus(8'h07, 1'b1);
        applyStimulus(8'h7A, 1'b0);
        checkOutput("badCount3", 32'(fifoCount), 3);
        base = capQ.size();
        busyForce = 1'b0;
        @(negedge clk);
        checkOutput("badCount2", 32'(fifoCount), 2);
        @(negedge clk);
        checkOutput("badCount1", 32'(fifoCount), 1);
        checkOutput("badNoStart", 32'(txStart), 0);
        repeat (30) @(negedge clk);
        checkOutput("badByteCount", 32'(capQ.size() - base), 1);
        if (capQ.size() > base) checkOutput("badByte", 32'(capQ[base]), 32'h7A);
        checkOutput("badCountEmpty", 32'(fifoCount), 0);

        // Escape expansion disabled
        base = cap2.size();
        keyCode = 8'h00; keySpecial = 1'b1; keyValid2 = 1'b1;
        @(negedge clk);
        keyCode = 8'h71; keySpecial = 1'b0;
        @(negedge clk);
        keyValid2 = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("noEscByteCount", 32'(cap2.size() - base), 1);
        if (cap2.size() > base) checkOutput("noEscByte", 32'(cap2[base]), 32'h71);
        checkOutput("noEscCount", 32'(fifoCount2), 0);
        checkOutput("noEscIdle", 32'(idle2), 1);

        // Reset during WAIT of byte1 with four entries queued
        doReset();
        busyForce = 1'b1;
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h61, 1'b0);
        applyStimulus(8'h62, 1'b0);
        applyStimulus(8'h63, 1'b0);
        checkOutput("midCount", 32'(fifoCount), 4);
        base = capQ.size();
        busyForce = 1'b0;
        for (int n = 0; n < 100 && capQ.size() - base < 2; n++) @(negedge clk);
        checkOutput("midByte1Seen", 32'(capQ.size() - base), 2);
        if (capQ.size() >= base + 2) checkOutput("midByte1", 32'(capQ[base+1]), 32'h5B);
        rst = 1'b0;
        #1;
        checkOutput("midRstTxStart", 32'(txStart), 0);
        checkOutput("midRstCount", 32'(fifoCount), 0);
        checkOutput("midRstOverflow", 32'(overflow), 0);
        checkOutput("midRstIdle", 32'(idle), 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("midNoMoreBytes", 32'(capQ.size() - base), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
